bsg_mem_nr1w_sync_hold: RTL and testbench



---
 rtl/bsg_mem_nr1w_sync_pkg.sv | 21 ++
 rtl/bsg_mem_nr1w_sync_read_port.sv | 72 +++++++
 rtl/bsg_mem_nr1w_sync_hold.sv | 130 +++++++++++++
 tb/tb_bsg_mem_nr1w_sync_hold.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_nr1w_sync_pkg.sv
// Shared state encoding and byte-merge helper for the N-read / 1-write sync RAM.
package bsg_mem_nr1w_sync_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      eInit  = 1'b0,
      eReady = 1'b1
   } bsg_mem_nr1w_state_e;

   // One byte lane of a masked write: take the new byte only when its mask bit is set.
   // Used by both the array write and the write-first bypass so the two cannot diverge.
   function automatic logic [BYTE_W-1:0] merge_byte(
      input logic [BYTE_W-1:0] i_old,
      input logic [BYTE_W-1:0] i_new,
      input logic              i_en
   );
      return i_en ? i_new : i_old;
   endfunction

endpackage

// File: rtl/bsg_mem_nr1w_sync_read_port.sv
// One synchronous read port: collision policy, out-of-range zeroing and the
// hold register that keeps the last accepted read on the output.
module bsg_mem_nr1w_sync_read_port
   import bsg_mem_nr1w_sync_pkg::*;
#(
   parameter int width_p                = 32,
   parameter int els_p                  = 8,
   parameter int addr_width_p           = 3,
   parameter int read_write_same_addr_p = 0
)(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_ready,
   input  logic                    i_r_v,
   input  logic [addr_width_p-1:0] i_r_addr,
   input  logic [width_p-1:0]      i_mem_word,
   input  logic                    i_w_v,
   input  logic [addr_width_p-1:0] i_w_addr,
   input  logic [width_p/8-1:0]    i_w_mask,
   input  logic [width_p-1:0]      i_w_data,
   output logic [width_p-1:0]      o_r_data,
   output logic                    o_r_v
);

   localparam int          MASK_W = width_p / BYTE_W;
   localparam logic [31:0] ELS_U  = 32'(els_p);

   logic                 w_accept;
   logic                 w_in_range;
   logic                 w_collide;
   logic [width_p-1:0]   w_merged;
   logic [width_p-1:0]   w_word;
   logic [width_p-1:0]   r_data;
   logic                 r_v;

   assign w_accept   = i_ready & i_r_v;
   assign w_in_range = 32'(i_r_addr) < ELS_U;
   assign w_collide  = i_w_v & (i_w_addr == i_r_addr);

   // Stored word with the concurrent write's enabled bytes substituted.
   for (genvar b = 0; b < MASK_W; b++) begin : g_byte
      assign w_merged[b*BYTE_W +: BYTE_W] = merge_byte(i_mem_word[b*BYTE_W +: BYTE_W],
                                                       i_w_data[b*BYTE_W +: BYTE_W],
                                                       i_w_mask[b]);
   end

   always_comb begin
      w_word = i_mem_word;
      if (!w_in_range) begin
         w_word = '0;
      end else if ((read_write_same_addr_p != 0) && w_collide) begin
         w_word = w_merged;
      end
   end

   // Hold register: only an accepted read reloads the data; valid is a one-cycle flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_data <= '0;
         r_v    <= 1'b0;
      end else begin
         r_v <= w_accept;
         if (w_accept) begin
            r_data <= w_word;
         end
      end
   end

   assign o_r_data = r_data;
   assign o_r_v    = r_v;

endmodule

// File: rtl/bsg_mem_nr1w_sync_hold.sv
// Register-file RAM: one byte-masked write port, read_ports_p synchronous held
// read ports, and an optional zeroing sweep after reset.
module bsg_mem_nr1w_sync_hold
   import bsg_mem_nr1w_sync_pkg::*;
#(
   parameter int width_p                = 32,
   parameter int els_p                  = 8,
   parameter int read_ports_p           = 2,
   parameter int read_write_same_addr_p = 0,
   parameter int clear_on_reset_p       = 1,
   parameter int addr_width_lp          = (els_p == 1) ? 1 : $clog2(els_p),
   parameter int mask_width_lp          = width_p / 8
)(
   input  logic                                        clk_i,
   input  logic                                        reset_i,
   output logic                                        ready_o,
   input  logic                                        w_v_i,
   input  logic [mask_width_lp-1:0]                    w_mask_i,
   input  logic [addr_width_lp-1:0]                    w_addr_i,
   input  logic [width_p-1:0]                          w_data_i,
   input  logic [read_ports_p-1:0]                     r_v_i,
   input  logic [read_ports_p-1:0][addr_width_lp-1:0]  r_addr_i,
   output logic [read_ports_p-1:0][width_p-1:0]        r_data_o,
   output logic [read_ports_p-1:0]                     r_v_o
);

   localparam logic [31:0]              ELS_U     = 32'(els_p);
   localparam logic [addr_width_lp-1:0] LAST_ADDR = addr_width_lp'(els_p - 1);

   bsg_mem_nr1w_state_e                       r_state;
   bsg_mem_nr1w_state_e                       w_state_next;
   logic [addr_width_lp-1:0]                  r_clear_addr;
   logic                                      w_ready;
   logic                                      w_clear_we;
   logic                                      w_write_we;
   logic                                      w_w_accept;
   logic                                      w_w_in_range;
   logic [width_p-1:0]                        r_mem [els_p];
   logic [read_ports_p-1:0][width_p-1:0]      w_mem_word;

   assign w_w_in_range = 32'(w_addr_i) < ELS_U;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= (clear_on_reset_p != 0) ? eInit : eReady;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: leave the sweep once the last entry has been cleared
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         eInit:   if (r_clear_addr == LAST_ADDR) w_state_next = eReady;
         eReady:  w_state_next = eReady;
         default: w_state_next = eReady;
      endcase
   end

   // Outputs: the sweep owns the write port until ready
   always_comb begin
      w_ready    = 1'b0;
      w_clear_we = 1'b0;
      w_w_accept = 1'b0;
      case (r_state)
         eInit: begin
            w_clear_we = ~reset_i;
         end
         eReady: begin
            w_ready    = 1'b1;
            w_w_accept = ~reset_i & w_v_i;
         end
         default: begin
            w_ready = 1'b0;
         end
      endcase
   end

   assign w_write_we = w_w_accept & w_w_in_range;
   assign ready_o    = w_ready;

   // Clear counter; reset always restarts the sweep at entry 0
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_clear_addr <= '0;
      end else if (w_clear_we && (r_clear_addr != LAST_ADDR)) begin
         r_clear_addr <= r_clear_addr + addr_width_lp'(1);
      end
   end

   // Storage array: not reset, zeroed only by the sweep
   always_ff @(posedge clk_i) begin
      if (w_clear_we) begin
         r_mem[r_clear_addr] <= '0;
      end else if (w_write_we) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            r_mem[w_addr_i][b*BYTE_W +: BYTE_W] <= merge_byte(r_mem[w_addr_i][b*BYTE_W +: BYTE_W],
                                                             w_data_i[b*BYTE_W +: BYTE_W],
                                                             w_mask_i[b]);
         end
      end
   end

   for (genvar p = 0; p < read_ports_p; p++) begin : g_port
      assign w_mem_word[p] = r_mem[r_addr_i[p]];

      bsg_mem_nr1w_sync_read_port #(
         .width_p               (width_p),
         .els_p                 (els_p),
         .addr_width_p          (addr_width_lp),
         .read_write_same_addr_p(read_write_same_addr_p)
      ) u_read_port (
         .i_clk     (clk_i),
         .i_reset   (reset_i),
         .i_ready   (w_ready),
         .i_r_v     (r_v_i[p]),
         .i_r_addr  (r_addr_i[p]),
         .i_mem_word(w_mem_word[p]),
         .i_w_v     (w_w_accept),
         .i_w_addr  (w_addr_i),
         .i_w_mask  (w_mask_i),
         .i_w_data  (w_data_i),
         .o_r_data  (r_data_o[p]),
         .o_r_v     (r_v_o[p])
      );
   end

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_hold.sv
// Bench for bsg_mem_nr1w_sync_hold: read-first and write-first instances driven
// in lockstep and compared against an array-based reference model.
module tb_bsg_mem_nr1w_sync_hold;

   localparam int W   = 32;
   localparam int ELS = 5;
   localparam int NP  = 2;
   localparam int AW  = 3;
   localparam int MW  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset;
   logic                   w_v;
   logic [MW-1:0]          w_mask;
   logic [AW-1:0]          w_addr;
   logic [W-1:0]           w_data;
   logic [NP-1:0]          r_v;
   logic [NP-1:0][AW-1:0]  r_addr;

   logic                   rdy0, rdy1;
   logic [NP-1:0][W-1:0]   rd0, rd1;
   logic [NP-1:0]          rv0, rv1;

   bsg_mem_nr1w_sync_hold #(
      .width_p(W), .els_p(ELS), .read_ports_p(NP),
      .read_write_same_addr_p(0), .clear_on_reset_p(1)
   ) u_dut_rf (
      .clk_i(clk), .reset_i(reset), .ready_o(rdy0),
      .w_v_i(w_v), .w_mask_i(w_mask), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd0), .r_v_o(rv0)
   );

   bsg_mem_nr1w_sync_hold #(
      .width_p(W), .els_p(ELS), .read_ports_p(NP),
      .read_write_same_addr_p(1), .clear_on_reset_p(1)
   ) u_dut_wf (
      .clk_i(clk), .reset_i(reset), .ready_o(rdy1),
      .w_v_i(w_v), .w_mask_i(w_mask), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd1), .r_v_o(rv1)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model
   logic [W-1:0] m_mem [ELS];
   int           m_swept;
   logic         m_ready;
   logic [W-1:0] exp_d [2][NP];
   logic         exp_v [2][NP];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] masked(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [MW-1:0] m);
      logic [W-1:0] bm;
      bm = '0;
      for (int b = 0; b < MW; b++) if (m[b]) bm = bm | (W'(32'hFF) << (8 * b));
      return (old_w & ~bm) | (new_w & bm);
   endfunction

   // Effect of one clock edge on the model, using the inputs present at that edge.
   function automatic void model_edge();
      logic [W-1:0] base;
      if (reset) begin
         m_swept = 0;
         m_ready = 1'b0;
         for (int q = 0; q < 2; q++)
            for (int p = 0; p < NP; p++) begin exp_v[q][p] = 1'b0; exp_d[q][p] = '0; end
      end else if (!m_ready) begin
         m_mem[m_swept] = '0;
         m_swept++;
         if (m_swept == ELS) m_ready = 1'b1;
         for (int q = 0; q < 2; q++)
            for (int p = 0; p < NP; p++) exp_v[q][p] = 1'b0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (r_v[p]) begin
               base = (int'(r_addr[p]) < ELS) ? m_mem[int'(r_addr[p])] : '0;
               exp_d[0][p] = base;
               exp_d[1][p] = (w_v && w_addr == r_addr[p] && int'(r_addr[p]) < ELS)
                             ? masked(base, w_data, w_mask) : base;
            end
            exp_v[0][p] = r_v[p];
            exp_v[1][p] = r_v[p];
         end
         if (w_v && int'(w_addr) < ELS)
            m_mem[int'(w_addr)] = masked(m_mem[int'(w_addr)], w_data, w_mask);
      end
   endfunction

   task automatic compare_all();
      check_val("ready_rf", 64'(rdy0), 64'(m_ready));
      check_val("ready_wf", 64'(rdy1), 64'(m_ready));
      for (int p = 0; p < NP; p++) begin
         check_val($sformatf("rv_rf_p%0d", p), 64'(rv0[p]), 64'(exp_v[0][p]));
         check_val($sformatf("rd_rf_p%0d", p), 64'(rd0[p]), 64'(exp_d[0][p]));
         check_val($sformatf("rv_wf_p%0d", p), 64'(rv1[p]), 64'(exp_v[1][p]));
         check_val($sformatf("rd_wf_p%0d", p), 64'(rd1[p]), 64'(exp_d[1][p]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_idle();
      w_v = 1'b0; w_mask = '0; w_addr = '0; w_data = '0;
      r_v = '0;   r_addr = '0;
   endtask

   task automatic set_random();
      w_v    = 1'($urandom_range(0, 1));
      w_mask = MW'($urandom);
      w_addr = AW'($urandom_range(0, 7));
      w_data = $urandom;
      for (int p = 0; p < NP; p++) begin
         r_v[p]    = 1'($urandom_range(0, 1));
         r_addr[p] = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom_range(0, 7));
      end
   endtask

   task automatic write_word(input int a, input logic [W-1:0] d, input logic [MW-1:0] m);
      w_v = 1'b1; w_addr = AW'(a); w_data = d; w_mask = m;
   endtask

   // Pulse reset, then count cycles until ready with optional random traffic.
   task automatic reset_and_sweep(input string tag, input bit noisy);
      int n;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n = 0;
      while (!rdy0 && n < 20) begin
         if (noisy) set_random(); else set_idle();
         step();
         n++;
      end
      check_val(tag, 64'(n), 64'(ELS));
      set_idle();
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      step();
      reset_and_sweep("sweep_len_first", 1'b0);

      // preload nonzero data, then a fresh sweep must zero it
      for (int i = 0; i < ELS; i++) begin
         write_word(i, 32'hA5A5_0000 | 32'(i + 1), '1);
         step();
      end
      set_idle();
      reset_and_sweep("sweep_len_preload", 1'b0);
      for (int i = 0; i < ELS; i++) begin
         r_v = 2'b11; r_addr[0] = AW'(i); r_addr[1] = AW'(ELS - 1 - i);
         step();
         check_val("clear_rd", 64'(rd0[0]), 64'h0);
      end

      // masked write then read
      set_idle(); write_word(3, 32'hAABB_CCDD, 4'b0101); step();
      set_idle(); r_v = 2'b11; r_addr[0] = 3'd3; r_addr[1] = 3'd3; step();
      check_val("mask_rd_p0", 64'(rd0[0]), 64'h00BB_00DD);
      check_val("mask_rd_p1", 64'(rd1[1]), 64'h00BB_00DD);

      // collision on both ports
      set_idle(); write_word(2, 32'h1111_1111, 4'hF); step();
      write_word(2, 32'h2222_2222, 4'hF); r_v = 2'b11; r_addr[0] = 3'd2; r_addr[1] = 3'd2; step();
      check_val("coll_rf_p0", 64'(rd0[0]), 64'h1111_1111);
      check_val("coll_rf_p1", 64'(rd0[1]), 64'h1111_1111);
      check_val("coll_wf_p0", 64'(rd1[0]), 64'h2222_2222);
      check_val("coll_wf_p1", 64'(rd1[1]), 64'h2222_2222);
      set_idle(); r_v = 2'b11; r_addr[0] = 3'd2; r_addr[1] = 3'd2; step();
      check_val("raw_next_rf", 64'(rd0[0]), 64'h2222_2222);

      // hold: later writes never disturb the held word
      set_idle(); write_word(4, 32'h5, 4'hF); step();
      set_idle(); r_v = 2'b01; r_addr[0] = 3'd4; step();
      check_val("hold_first", 64'(rd0[0]), 64'h5);
      check_val("hold_v_first", 64'(rv0[0]), 64'h1);
      for (int i = 0; i < 3; i++) begin
         set_idle(); write_word(4, 32'h9, 4'hF); step();
         check_val("hold_data", 64'(rd1[0]), 64'h5);
         check_val("hold_v", 64'(rv1[0]), 64'h0);
      end

      // out-of-range write dropped, read returns zero with valid
      set_idle(); write_word(6, 32'hDEAD_BEEF, 4'hF); step();
      set_idle(); r_v = 2'b11; r_addr[0] = 3'd6; r_addr[1] = 3'd4; step();
      check_val("oor_rd", 64'(rd0[0]), 64'h0);
      check_val("oor_v", 64'(rv0[0]), 64'h1);
      check_val("oor_neighbor", 64'(rd0[1]), 64'h9);

      // reset in ready discards held data
      set_idle(); reset = 1'b1; step();
      check_val("rst_discard_d", 64'(rd0[1]), 64'h0);
      check_val("rst_discard_v", 64'(rv0[0]), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin set_random(); step(); end
      reset_and_sweep("sweep_len_restart", 1'b1);
      for (int i = 0; i < ELS; i++) begin
         r_v = 2'b11; r_addr[0] = AW'(i); r_addr[1] = AW'(i);
         step();
         check_val("restart_clear", 64'(rd1[1]), 64'h0);
      end

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         set_random();
         reset = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0;
      set_idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
